// File: rtl/prog_loader_if.sv
// Byte-stream receive handshake plus program RAM write port of the loader.
//   rx_valid / rx_data : byte offered by the host receiver
//   rx_ready           : loader can take the byte (transfer on valid && ready)
//   wr_en / wr_addr / wr_data : program RAM write port, one write per strobe
// Modports: master = loader side, slave = host / RAM side.
interface prog_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/prog_loader.sv
// Program RAM loader. Accepts a frame SYNC, LEN (0 = 256), payload, checksum
// over the byte stream, writes the payload from address 0, fills the rest of
// the 256-byte store with FILL_BYTE and releases the CPU only after a frame
// with a matching 8-bit additive checksum.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : one-cycle load request (honoured in IDLE/DONE/ERR)
//   bus           : rx handshake and RAM write port (master modport)
//   cpu_hold      : CPU reset, low only after a successful load
//   load_done     : successful load level
//   load_error    : checksum error or inter-byte timeout level
//   byte_count    : payload bytes accepted in the current frame
module prog_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  FILL_BYTE      = 8'h0F,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    prog_loader_if.master      bus,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_error,
    output logic [8:0]         byte_count
);

    typedef enum logic [2:0] {IDLE, HDR, LEN, DATA, CSUM, FILL, DONE, ERR} state_t;

    state_t      state_reg, state_next;
    logic [8:0]  len_reg, len_next;
    logic [7:0]  csum_reg, csum_next;
    logic [7:0]  addr_reg, addr_next;
    logic [15:0] timer_reg, timer_next;
    logic [8:0]  count_reg, count_next;
    logic        wr_en_reg, wr_en_next;
    logic [7:0]  wr_addr_reg, wr_addr_next;
    logic [7:0]  wr_data_reg, wr_data_next;
    logic        accept;
    logic        armed;

    assign bus.rx_ready = (state_reg == HDR) || (state_reg == LEN) ||
                          (state_reg == DATA) || (state_reg == CSUM);
    assign accept = bus.rx_valid && bus.rx_ready;
    // Timer runs only while a frame is in progress and a limit is set.
    assign armed  = ((state_reg == LEN) || (state_reg == DATA) || (state_reg == CSUM)) &&
                    (TIMEOUT_CYCLES != 16'd0);

    // Payload writes are registered (one clock behind acceptance); fill
    // writes are driven straight from FILL so none of them spill into DONE.
    assign bus.wr_en   = wr_en_reg || (state_reg == FILL);
    assign bus.wr_addr = (state_reg == FILL) ? addr_reg  : wr_addr_reg;
    assign bus.wr_data = (state_reg == FILL) ? FILL_BYTE : wr_data_reg;

    assign cpu_hold   = (state_reg != DONE);
    assign load_done  = (state_reg == DONE);
    assign load_error = (state_reg == ERR);
    assign byte_count = count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            len_reg     <= '0;
            csum_reg    <= '0;
            addr_reg    <= '0;
            timer_reg   <= '0;
            count_reg   <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            csum_reg    <= csum_next;
            addr_reg    <= addr_next;
            timer_reg   <= timer_next;
            count_reg   <= count_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        csum_next    = csum_reg;
        addr_next    = addr_reg;
        timer_next   = '0;
        count_next   = count_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;

        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = HDR;
                    csum_next  = '0;
                    addr_next  = '0;
                    count_next = '0;
                end
            end
            HDR: begin
                if (accept && (bus.rx_data == SYNC_BYTE))
                    state_next = LEN;
            end
            LEN: begin
                if (accept) begin
                    len_next   = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
                    state_next = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = addr_reg;
                    wr_data_next = bus.rx_data;
                    addr_next    = addr_reg + 8'd1;
                    csum_next    = csum_reg + bus.rx_data;
                    count_next   = count_reg + 9'd1;
                    if ((count_reg + 9'd1) == len_reg)
                        state_next = CSUM;
                end
            end
            CSUM: begin
                if (accept) begin
                    if (bus.rx_data != csum_reg)
                        state_next = ERR;
                    else if (len_reg == 9'd256)
                        state_next = DONE;
                    else
                        state_next = FILL;
                end
            end
            FILL: begin
                // Stop at 0xFF rather than wrapping into the payload region.
                if (addr_reg == 8'hFF)
                    state_next = DONE;
                else
                    addr_next = addr_reg + 8'd1;
            end
            default: state_next = IDLE;
        endcase

        // An accepted byte beats an expiring timer in the same cycle.
        if (armed && !accept) begin
            if ((timer_reg + 16'd1) == TIMEOUT_CYCLES)
                state_next = ERR;
            else
                timer_next = timer_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cpu_hold, load_done, load_error;
    logic [8:0] byte_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_m [256];
    int         wr_total = 0;
    logic [7:0] pay [256];

    prog_loader_if bus();

    prog_loader #(
        .SYNC_BYTE(8'hA5), .FILL_BYTE(8'h0F), .TIMEOUT_CYCLES(16'd16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // RAM model fed from the write port, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            ram_m[bus.wr_addr] = bus.wr_data;
            wr_total++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Offers one byte after 'gap' idle cycles; returns 1 ns after the
    // accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!bus.rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] csum, input int maxgap);
        send_byte(8'hA5, 0);
        send_byte((n == 256) ? 8'h00 : n[7:0], 0);
        for (int i = 0; i < n; i++) send_byte(pay[i], $urandom_range(0, maxgap));
        send_byte(csum, 0);
    endtask

    // Runs until done/error; counts write strobes and rx_ready cycles seen.
    task automatic wait_end(output int wr_seen, output int rdy_seen);
        int n;
        n = 0; wr_seen = 0; rdy_seen = 0;
        while (!load_done && !load_error && n < 1000) begin
            @(negedge clk);
            if (!load_done && !load_error) begin
                if (bus.wr_en) wr_seen++;
                if (bus.rx_ready) rdy_seen++;
            end
            n++;
        end
        if (n >= 1000) check("end_timeout", 0, 1);
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 256; i++) ram_m[i] = 8'hEE;
    endtask

    initial begin
        int wr_seen, rdy_seen, bad, snap;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        clear_ram();

        // Reset values
        #2;
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_outputs", {load_done, load_error, bus.wr_en, bus.rx_ready, bus.wr_addr, bus.wr_data, byte_count}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle for 100 clocks
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!cpu_hold || bus.rx_ready || bus.wr_en) bad++;
        end
        check("idle_100", bad, 0);

        // HDR waits indefinitely; timer is not armed there
        pulse_start();
        repeat (100) @(negedge clk);
        check("hdr_wait", {bus.rx_ready, load_error, cpu_hold}, 3'b101);

        // Normal short load, each write one clock after acceptance
        clear_ram();
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'hD1, 0);
        check("wr0", {bus.wr_en, bus.wr_addr, bus.wr_data}, {1'b1, 8'h00, 8'hD1});
        send_byte(8'hC4, 0);
        check("wr1", {bus.wr_en, bus.wr_addr, bus.wr_data}, {1'b1, 8'h01, 8'hC4});
        send_byte(8'h01, 0);
        check("wr2", {bus.wr_en, bus.wr_addr, bus.wr_data}, {1'b1, 8'h02, 8'h01});
        send_byte(8'h96, 0);
        wait_end(wr_seen, rdy_seen);
        check("short_fill_writes", wr_seen, 253);
        check("short_fill_rdy", rdy_seen, 0);
        bad = 0;
        for (int i = 3; i < 256; i++) if (ram_m[i] !== 8'h0F) bad++;
        check("short_fill_ram", bad, 0);
        check("short_payload_ram", {ram_m[0], ram_m[1], ram_m[2]}, 24'hD1C401);
        @(negedge clk);
        check("short_done", {load_done, load_error, cpu_hold, bus.wr_en}, 4'b1000);
        check("short_count", byte_count, 3);

        // Full image: no fill
        clear_ram();
        for (int i = 0; i < 256; i++) pay[i] = i[7:0];
        snap = wr_total;
        pulse_start();
        send_frame(256, 8'h80, 0);
        wait_end(wr_seen, rdy_seen);
        check("full_no_fill", wr_seen, 0);
        check("full_writes", wr_total - snap, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram_m[i] !== i[7:0]) bad++;
        check("full_ram", bad, 0);
        @(negedge clk);
        check("full_done", {load_done, cpu_hold}, 2'b10);
        check("full_count", byte_count, 256);

        // Bad checksum
        snap = wr_total;
        pulse_start();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h55, 0);
        send_byte(8'h54, 0);
        repeat (20) @(negedge clk);
        check("bad_err", {load_error, load_done, cpu_hold}, 3'b101);
        check("bad_writes", wr_total - snap, 1);

        // Recovery with a valid frame
        pulse_start();
        pay[0] = 8'h42;
        send_frame(1, 8'h42, 0);
        wait_end(wr_seen, rdy_seen);
        @(negedge clk);
        check("recover_done", {load_done, load_error, cpu_hold}, 3'b100);

        // Header hunting and random backpressure
        clear_ram();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30; pay[3] = 8'hA5; pay[4] = 8'h05;
        send_frame(5, 8'h0A, 3);
        wait_end(wr_seen, rdy_seen);
        check("hunt_fill_writes", wr_seen, 251);
        check("hunt_fill_rdy", rdy_seen, 0);
        check("hunt_ram", {ram_m[0], ram_m[1], ram_m[2], ram_m[3], ram_m[4], ram_m[5]}, 48'h102030A5050F);
        @(negedge clk);
        check("hunt_done", {load_done, byte_count}, {1'b1, 9'd5});

        // Timeout: 16 idle clocks after the LEN byte
        pulse_start();
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        repeat (15) @(posedge clk);
        #1 check("tmo_not_yet", load_error, 0);
        @(posedge clk);
        #1 check("tmo_err", {load_error, cpu_hold}, 2'b11);

        // Asynchronous reset mid-DATA
        pulse_start();
        send_byte(8'hA5, 0);
        send_byte(8'h08, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        check("pre_rst_wr", bus.wr_en, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_outputs", {cpu_hold, load_done, load_error, bus.wr_en, bus.rx_ready, byte_count}, {1'b1, 13'd0});
        snap = wr_total;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("arst_no_writes", wr_total - snap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
